// File: rtl/overlap_add_stage.sv
// overlap_add_stage: overlap-adds 3-segment blocks into a segment stream; `define OVADD_BLKCNT_EN adds the blk_cnt port
module overlap_add_stage #(
  parameter int SEG_W = 7,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [SEG_W-1:0] y0,
  input  logic [SEG_W-1:0] y1,
  input  logic [SEG_W-1:0] y2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
`ifdef OVADD_BLKCNT_EN
  output logic [7:0]       blk_cnt,
`endif
  output logic             out_last
);
  if (OUT_W < SEG_W + 1) begin : g_width_chk
    $error("overlap_add_stage: OUT_W must be at least SEG_W+1");
  end
  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1, EMIT_TAIL} state_t;
  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [SEG_W-1:0] tail_q, tail_d;
  logic [SEG_W-1:0] s1_q, s1_d;
  logic [SEG_W-1:0] s2_q, s2_d;
  logic             last_q, last_d;
  logic             in_fire, out_fire, load;
  assign in_ready  = (state_q == IDLE) | ((state_q == EMIT1) & out_ready & ~last_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  // next-state: walk the three beats of each block, folding the held tail into the next y0
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    tail_d      = tail_q;
    load        = 1'b0;
    case (state_q)
      IDLE: if (in_fire) begin
        out_data_d  = OUT_W'(y0) + OUT_W'(tail_q);
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        load        = 1'b1;
        state_d     = EMIT0;
      end
      EMIT0: if (out_fire) begin
        out_data_d = OUT_W'(s1_q);
        state_d    = EMIT1;
      end
      EMIT1: if (out_fire) begin
        if (last_q) begin
          out_data_d = OUT_W'(s2_q);
          out_last_d = 1'b1;
          state_d    = EMIT_TAIL;
        end else if (in_fire) begin
          out_data_d = OUT_W'(y0) + OUT_W'(s2_q);
          tail_d     = s2_q;
          load       = 1'b1;
          state_d    = EMIT0;
        end else begin
          tail_d      = s2_q;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      EMIT_TAIL: if (out_fire) begin
        tail_d      = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
    s1_d   = load ? y1 : s1_q;
    s2_d   = load ? y2 : s2_q;
    last_d = load ? in_last : last_q;
  end
  // state and registered outputs; reset drops any pending beat and tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      tail_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      tail_q      <= tail_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      last_q      <= last_d;
    end
  end
`ifdef OVADD_BLKCNT_EN
  logic [7:0] blk_cnt_q, blk_cnt_d;
  // saturating count of blocks in the current frame, cleared as the tail beat leaves
  always_comb blk_cnt_d = (state_q == EMIT_TAIL && out_fire) ? 8'd0 :
                          (in_fire && blk_cnt_q != 8'hFF) ? blk_cnt_q + 8'd1 : blk_cnt_q;
  // block counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_cnt_q <= 8'd0;
    else blk_cnt_q <= blk_cnt_d;
  end
  assign blk_cnt = blk_cnt_q;
`endif
endmodule

// File: tb/tb_overlap_add_stage.sv
// tb_overlap_add_stage: table vectors, stall/reset sequences and random frames against a beat-queue model
module tb_overlap_add_stage;
  localparam int SEG_W = 7;
  localparam int OUT_W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [SEG_W-1:0] y0 = '0, y1 = '0, y2 = '0;
  logic [OUT_W-1:0] out_data;
`ifdef OVADD_BLKCNT_EN
  logic [7:0] blk_cnt;
`endif
  int n_checks = 0, n_pass = 0, cyc = 0, ready_mode = 0, m_tail = 0;
  int got_data[$], got_cyc[$], exp_data[$], fire_cyc[$];
  bit got_lst[$], exp_lst[$];
  typedef struct {int y0; int y1; int y2; bit last; int e0; int e1; int e2;} vec_t;
  vec_t vecs[7];

  overlap_add_stage #(.SEG_W(SEG_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .y0(y0), .y1(y1), .y2(y2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef OVADD_BLKCNT_EN
    .blk_cnt(blk_cnt),
`endif
    .out_last(out_last));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // downstream: always ready, random stalls, or stalled
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // monitor: collects fired beats, checks hold-while-stalled and in_ready per beat position
  int j = 0, prev_data = 0;
  bit cur_last = 0, prev_stall = 0, prev_last = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      j = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), prev_data);
        chk("hold_last", int'(out_last), int'(prev_last));
      end
      chk("in_ready", int'(in_ready), !out_valid ? 1 : int'(j == 1 && !cur_last && out_ready));
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_lst.push_back(out_last);
        got_cyc.push_back(cyc);
        j++;
      end
      if (in_valid && in_ready) begin
        j = 0;
        cur_last = in_last;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);
      prev_last  = out_last;
    end
  end

  task automatic push_exp(int d, bit l);
    exp_data.push_back(d);
    exp_lst.push_back(l);
  endtask

  // reference: each block yields y0+tail, y1, and y2 only when it closes the frame
  task automatic model_blk(int a, int b, int c, bit last);
    push_exp(a + m_tail, 0);
    push_exp(b, 0);
    if (last) begin
      push_exp(c, 1);
      m_tail = 0;
    end else m_tail = c;
  endtask

  task automatic send(int a, int b, int c, bit last, bit use_model);
    int budget;
    bit done;
    budget = 200;
    done = 0;
    y0 = SEG_W'(a);
    y1 = SEG_W'(b);
    y2 = SEG_W'(c);
    in_last = last;
    in_valid = 1'b1;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        fire_cyc.push_back(cyc);
        if (use_model) model_blk(a, b, c, last);
        done = 1;
      end
      budget--;
    end
    if (!done) chk("in_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic compare(string tag);
    int budget, n;
    budget = 400;
    while (got_data.size() < exp_data.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_beat_count"}, got_data.size(), exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d_data", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_beat%0d_last", tag, i), int'(got_lst[i]), int'(exp_lst[i]));
    end
    got_data.delete();
    got_lst.delete();
    exp_data.delete();
    exp_lst.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5, 9, 3, 1, 5, 9, 3};
    vecs[1] = '{10, 20, 30, 0, 10, 20, 0};
    vecs[2] = '{1, 2, 4, 1, 31, 2, 4};
    vecs[3] = '{127, 0, 127, 0, 127, 0, 0};
    vecs[4] = '{127, 1, 127, 1, 254, 1, 127};
    vecs[5] = '{1, 1, 50, 1, 1, 1, 50};
    vecs[6] = '{7, 3, 3, 1, 7, 3, 3};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_last", int'(out_last), 0);
`ifdef OVADD_BLKCNT_EN
    chk("reset_blk_cnt", int'(blk_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      push_exp(vecs[i].e0, 0);
      push_exp(vecs[i].e1, 0);
      if (vecs[i].last) push_exp(vecs[i].e2, 1);
      send(vecs[i].y0, vecs[i].y1, vecs[i].y2, vecs[i].last, 0);
    end
    compare("table");
    if (got_cyc.size() >= 8 && fire_cyc.size() >= 1) begin
      chk("first_beat_latency", got_cyc[0] - fire_cyc[0], 1);
      chk("b2b_no_gap", got_cyc[7] - got_cyc[3], 4);
    end else chk("stamp_count", got_cyc.size(), 8);
    got_cyc.delete();
    fire_cyc.delete();
    ready_mode = 1;
    send(11, 22, 33, 0, 1);
    send(44, 55, 66, 0, 1);
    send(77, 88, 99, 1, 1);
    compare("stall");
    for (int f = 0; f < 8; f++) begin
      int nb;
      ready_mode = f % 2;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        send($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), b == nb - 1, 1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    compare("rand");
    ready_mode = 0;
    push_exp(1, 0);
    push_exp(2, 0);
    push_exp(43, 0);
    send(1, 2, 40, 0, 0);
    send(3, 4, 5, 0, 0);
    #1;
    ready_mode = 2;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_emit1_data", int'(out_data), 4);
`ifdef OVADD_BLKCNT_EN
    chk("pre_reset_blk_cnt", int'(blk_cnt), 2);
`endif
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", int'(out_valid), 0);
    chk("async_reset_out_data", int'(out_data), 0);
    chk("async_reset_out_last", int'(out_last), 0);
`ifdef OVADD_BLKCNT_EN
    chk("async_reset_blk_cnt", int'(blk_cnt), 0);
`endif
    compare("pre_reset");
    @(negedge clk);
    rst = 1'b0;
    m_tail = 0;
    ready_mode = 0;
    @(posedge clk);
    #1;
    send(6, 7, 8, 1, 1);
    chk("post_reset_first_beat", int'(out_data), 6);
`ifdef OVADD_BLKCNT_EN
    chk("post_reset_blk_cnt", int'(blk_cnt), 1);
`endif
    compare("post_reset");
`ifdef OVADD_BLKCNT_EN
    chk("frame_end_blk_cnt", int'(blk_cnt), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/overlap_add_stage.md
Name: overlap_add_stage

Overview:
- Downstream consumer of the 2x2 segment convolver. Accepts one block of segment partial results per handshake: y0 = x0*h0, y1 = x1*h0 + x0*h1, y2 = x1*h1.
- Performs overlap-add across consecutive blocks: the y2 tail of block k is added to y0 of block k+1.
- Streams the result one segment per handshake on a valid/ready output bus.
- in_last marks the final block of a frame; the pending tail is then flushed.

Parameters:
- SEG_W, 7: width of each incoming segment result y0/y1/y2.
- OUT_W, 8: output segment width; must be >= SEG_W+1 (elaboration-time check, $error if violated).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  block present on y0/y1/y2/in_last.
- in_ready  out  1  stage can accept a block this cycle.
- in_last  in  1  block is last of frame.
- y0  in  SEG_W  segment 0 result.
- y1  in  SEG_W  segment 1 result (already summed cross terms).
- y2  in  SEG_W  segment 2 result (tail).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_W  output segment.
- out_last  out  1  out_data is final segment of frame.

Behaviour:
- Reset (async assert, sync release to clk): state=IDLE, out_valid=0, out_data=0, out_last=0, tail=0, s1_r=0, s2_r=0, last_r=0.
- Handshakes: in fire = in_valid & in_ready; out fire = out_valid & out_ready.
- Output stability: out_data/out_last held stable while out_valid & !out_ready. out_valid never drops without a fire.
- All outputs are registered. Latency from in fire to first out_valid is 1 cycle.
- States: IDLE, EMIT0, EMIT1, EMIT_TAIL.
- IDLE:
  - in_ready=1.
  - On in fire: out_data <= zext(y0) + zext(tail); s1_r <= y1; s2_r <= y2; last_r <= in_last; out_valid <= 1; out_last <= 0; go EMIT0.
- EMIT0:
  - in_ready=0.
  - On out fire: out_data <= zext(s1_r); go EMIT1.
  - out_last stays 0.
- EMIT1:
  - in_ready = out_ready & !last_r.
  - On out fire with last_r=1: out_data <= zext(s2_r); out_last <= 1; go EMIT_TAIL.
  - On out fire with last_r=0 and no in fire: tail <= s2_r; out_valid <= 0; go IDLE.
  - On out fire with last_r=0 and simultaneous in fire (back-to-back): out_data <= zext(y0) + zext(s2_r); tail <= s2_r; load s1_r/s2_r/last_r from the new block; go EMIT0 with out_valid held 1.
  - Sustained throughput is one block per 2 output beats.
- EMIT_TAIL:
  - in_ready=0.
  - On out fire: tail <= 0; out_valid <= 0; out_last <= 0; go IDLE.
  - The next frame starts with tail=0.
- Arithmetic: unsigned; sum max 2*(2^SEG_W-1) fits OUT_W, so there is no overflow or wrap.
- Frame boundary: frame of N blocks produces exactly 2N+1 output beats; out_last only on beat 2N+1.
- Single-block frame (in_last on first block): 3 beats y0, y1, y2.
- Reset mid-operation discards any pending beat and tail. The first block after reset sees tail=0.
- in_valid while in_ready=0: inputs ignored; upstream must hold.

Optional Feature:
- Macro: OVADD_BLKCNT_EN.
- Defined:
  - Adds output port blk_cnt (out, 8): number of blocks accepted in the current frame.
  - Increments on every in fire, saturating at 255.
  - Cleared to 0 on the EMIT_TAIL out fire and on reset.
  - Updates the cycle after in fire.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Single-block frame: y0=5, y1=9, y2=3, in_last=1, out_ready=1 -> beats 5, 9, 3; out_last only on 3; first out_valid 1 cycle after fire.
- Two-block frame back-to-back, out_ready=1:
  - Block A y0=10, y1=20, y2=30, last=0; block B y0=1, y1=2, y2=4, last=1.
  - Expect beats 10, 20, 31, 2, 4 with no idle cycle between 20 and 31; out_last on 4.
- Max values: y0=y2=127 on consecutive blocks -> overlap beat 254 (8'hFE), no wrap.
- Backpressure: out_ready toggled 1-0-0-1 pseudo-randomly during a 3-block frame.
  - out_data/out_last stable while stalled.
  - in_ready=0 in EMIT0/EMIT_TAIL.
  - Beat sequence identical to the no-stall run.
- Frame isolation: frame 1 ends with y2=50; frame 2 first block y0=7 -> first beat of frame 2 is 7, not 57.
- Async reset asserted in EMIT1 with tail=40:
  - Outputs go 0 immediately (no clock needed).
  - Next block y0=6 emits 6.
  - With OVADD_BLKCNT_EN, blk_cnt reads 0 after reset and 1 after that fire.
